// File: rtl/ras_predecode_if.sv
// Fetch-to-decode bus of ras_predecode: the accepted instruction word on the way in,
// and the registered slot with its prediction on the way out.
interface ras_predecode_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [ADDR_WIDTH-1:0] in_pc_i;
  logic [31:0]           in_instr_i;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [ADDR_WIDTH-1:0] out_pc_o;
  logic [31:0]           out_instr_o;
  logic                  out_pred_taken_o;
  logic [ADDR_WIDTH-1:0] out_pred_target_o;
  logic                  out_is_call_o;
  logic                  out_is_ret_o;

  // Fetch/decode side of the bus.
  modport master (
    output in_valid_i, in_pc_i, in_instr_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_pc_o, out_instr_o,
           out_pred_taken_o, out_pred_target_o, out_is_call_o, out_is_ret_o
  );

  // The predecode block itself.
  modport slave (
    input  in_valid_i, in_pc_i, in_instr_i, out_ready_i,
    output in_ready_o, out_valid_o, out_pc_o, out_instr_o,
           out_pred_taken_o, out_pred_target_o, out_is_call_o, out_is_ret_o
  );
endinterface

// File: rtl/ras_predecode.sv
// Fetch-stage predecode: classifies calls/returns by link-register hints, drives the
// return-stack strobes and registers the word plus its next-PC prediction for decode.
module ras_predecode #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  ras_predecode_if.slave        bus,
  output logic                  rsb_push_en_o,
  output logic [ADDR_WIDTH-1:0] rsb_push_addr_o,
  output logic                  rsb_pop_en_o,
  input  logic [ADDR_WIDTH-1:0] rsb_pop_addr_i,
  input  logic                  rsb_pop_valid_i,
  output logic                  redirect_valid_o,
  output logic [ADDR_WIDTH-1:0] redirect_pc_o,
  output logic [CNT_WIDTH-1:0]  call_cnt_o,
  output logic [CNT_WIDTH-1:0]  ret_cnt_o,
  output logic [CNT_WIDTH-1:0]  ret_miss_cnt_o
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [31:0]           instr;
    logic                  taken;
    logic [ADDR_WIDTH-1:0] target;
    logic                  is_call;
    logic                  is_ret;
  } slot_t;

  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;

  slot_t                 slot_q, slot_d;
  logic                  out_valid_q, out_valid_d;
  logic                  redirect_valid_q, redirect_valid_d;
  logic [ADDR_WIDTH-1:0] redirect_pc_q, redirect_pc_d;
  logic [CNT_WIDTH-1:0]  call_cnt_q, call_cnt_d;
  logic [CNT_WIDTH-1:0]  ret_cnt_q, ret_cnt_d;
  logic [CNT_WIDTH-1:0]  ret_miss_cnt_q, ret_miss_cnt_d;

  logic                  in_ready, accept;
  logic                  is_jal, is_jalr, link_rd, link_rs1, is_call, is_ret, taken;
  logic [4:0]            rd, rs1;
  logic [20:0]           j_imm;
  logic [ADDR_WIDTH-1:0] pc_plus4, target;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(logic [CNT_WIDTH-1:0] cnt, logic en);
    return (en && (cnt != '1)) ? cnt + 1'b1 : cnt;
  endfunction

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    rd       = bus.in_instr_i[11:7];
    rs1      = bus.in_instr_i[19:15];
    j_imm    = {bus.in_instr_i[31], bus.in_instr_i[19:12], bus.in_instr_i[20],
                bus.in_instr_i[30:21], 1'b0};
    is_jal   = bus.in_instr_i[6:0] == OPC_JAL;
    is_jalr  = (bus.in_instr_i[6:0] == OPC_JALR) && (bus.in_instr_i[14:12] == 3'b000);
    link_rd  = (rd == 5'd1) || (rd == 5'd5);
    link_rs1 = (rs1 == 5'd1) || (rs1 == 5'd5);
    is_call  = (is_jal || is_jalr) && link_rd;
    // A linking JALR through its own rd is a plain call, not a co-routine swap.
    is_ret   = is_jalr && link_rs1 && (!link_rd || (rd != rs1));
    taken    = is_jal || (is_ret && rsb_pop_valid_i);
    pc_plus4 = bus.in_pc_i + ADDR_WIDTH'(4);
    target   = pc_plus4;
    if (is_jal) begin
      target = bus.in_pc_i + ADDR_WIDTH'(signed'(j_imm));
    end else if (is_ret && rsb_pop_valid_i) begin
      target = rsb_pop_addr_i;
    end

    in_ready = !flush_i && (!out_valid_q || bus.out_ready_i);
    accept   = bus.in_valid_i && in_ready;

    slot_d           = slot_q;
    out_valid_d      = out_valid_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    if (flush_i) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d      = 1'b1;
      slot_d           = '{pc: bus.in_pc_i, instr: bus.in_instr_i, taken: taken,
                           target: target, is_call: is_call, is_ret: is_ret};
      redirect_valid_d = taken;
      redirect_pc_d    = taken ? target : redirect_pc_q;
    end else if (bus.out_ready_i) begin
      out_valid_d = 1'b0;
    end

    call_cnt_d     = sat_inc(call_cnt_q, accept && is_call);
    ret_cnt_d      = sat_inc(ret_cnt_q, accept && is_ret);
    ret_miss_cnt_d = sat_inc(ret_miss_cnt_q, accept && is_ret && !rsb_pop_valid_i);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_q           <= '0;
      out_valid_q      <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      call_cnt_q       <= '0;
      ret_cnt_q        <= '0;
      ret_miss_cnt_q   <= '0;
    end else begin
      slot_q           <= slot_d;
      out_valid_q      <= out_valid_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      call_cnt_q       <= call_cnt_d;
      ret_cnt_q        <= ret_cnt_d;
      ret_miss_cnt_q   <= ret_miss_cnt_d;
    end
  end

  // Strobes are also gated by reset so a word held valid during reset never reaches the RSB.
  assign rsb_push_en_o   = rst_ni && accept && is_call;
  assign rsb_pop_en_o    = rst_ni && accept && is_ret;
  assign rsb_push_addr_o = pc_plus4;

  assign bus.in_ready_o        = in_ready;
  assign bus.out_valid_o       = out_valid_q;
  assign bus.out_pc_o          = slot_q.pc;
  assign bus.out_instr_o       = slot_q.instr;
  assign bus.out_pred_taken_o  = slot_q.taken;
  assign bus.out_pred_target_o = slot_q.target;
  assign bus.out_is_call_o     = slot_q.is_call;
  assign bus.out_is_ret_o      = slot_q.is_ret;

  // A flush in the pulse cycle means the predicted path is already dead.
  assign redirect_valid_o = redirect_valid_q && !flush_i;
  assign redirect_pc_o    = redirect_pc_q;
  assign call_cnt_o       = call_cnt_q;
  assign ret_cnt_o        = ret_cnt_q;
  assign ret_miss_cnt_o   = ret_miss_cnt_q;

endmodule

// File: tb/tb_ras_predecode.sv
// Directed bench for ras_predecode: call/return classification, RSB strobes,
// prediction, redirect pulse, backpressure, flush, counter saturation and reset.
module tb_ras_predecode;
  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic        rsb_push_en_o, rsb_pop_en_o, rsb_pop_valid_i, redirect_valid_o;
  logic [31:0] rsb_push_addr_o, rsb_pop_addr_i, redirect_pc_o;
  logic [15:0] call_cnt_o, ret_cnt_o, ret_miss_cnt_o;
  int          checks = 0;
  int          errors = 0;

  ras_predecode_if #(.ADDR_WIDTH(32)) bus ();

  ras_predecode #(.ADDR_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .bus(bus),
    .rsb_push_en_o(rsb_push_en_o), .rsb_push_addr_o(rsb_push_addr_o),
    .rsb_pop_en_o(rsb_pop_en_o), .rsb_pop_addr_i(rsb_pop_addr_i),
    .rsb_pop_valid_i(rsb_pop_valid_i), .redirect_valid_o(redirect_valid_o),
    .redirect_pc_o(redirect_pc_o), .call_cnt_o(call_cnt_o), .ret_cnt_o(ret_cnt_o),
    .ret_miss_cnt_o(ret_miss_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  localparam logic [31:0] JAL_X1_P100  = 32'h100000EF;  // jal x1,+0x100
  localparam logic [31:0] JAL_X0_P100  = 32'h1000006F;  // jal x0,+0x100
  localparam logic [31:0] JAL_X0_M4    = 32'hFFDFF06F;  // jal x0,-4
  localparam logic [31:0] RET_X1       = 32'h00008067;  // jalr x0,0(x1)
  localparam logic [31:0] JALR_X1_X5   = 32'h000280E7;  // jalr x1,0(x5)
  localparam logic [31:0] JALR_X1_X6   = 32'h000300E7;  // jalr x1,0(x6)
  localparam logic [31:0] JALR_X1_X1   = 32'h000080E7;  // jalr x1,0(x1)
  localparam logic [31:0] JALR_F3_X1   = 32'h00009067;  // funct3=1, not a JALR
  localparam logic [31:0] NOP          = 32'h00000013;

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr);
    bus.in_valid_i = v;
    bus.in_pc_i    = pc;
    bus.in_instr_i = instr;
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; flush_i = 1'b0; bus.out_ready_i = 1'b1;
    rsb_pop_valid_i = 1'b1; rsb_pop_addr_i = 32'h0;
    drive(1'b1, 32'h100, RET_X1);
    checks++; if (rsb_pop_en_o !== 1'b0) begin errors++; $display("FAIL reset_pop_en: got %0h want 0", rsb_pop_en_o); end
    cyc();
    checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0h want 0", bus.out_valid_o); end
    checks++; if (redirect_valid_o !== 1'b0) begin errors++; $display("FAIL reset_redirect: got %0h want 0", redirect_valid_o); end
    checks++; if ({call_cnt_o, ret_cnt_o, ret_miss_cnt_o} !== 48'h0) begin errors++; $display("FAIL reset_counters: got %h want 0", {call_cnt_o, ret_cnt_o, ret_miss_cnt_o}); end
    checks++; if ({bus.out_pc_o, bus.out_instr_o, bus.out_pred_target_o, redirect_pc_o} !== 128'h0) begin errors++; $display("FAIL reset_fields: got %h want 0", {bus.out_pc_o, bus.out_instr_o, bus.out_pred_target_o, redirect_pc_o}); end
    checks++; if ({bus.out_pred_taken_o, bus.out_is_call_o, bus.out_is_ret_o} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {bus.out_pred_taken_o, bus.out_is_call_o, bus.out_is_ret_o}); end
    checks++; if (bus.in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0h want 1", bus.in_ready_o); end
    drive(1'b0, 32'h0, NOP);
    @(negedge clk_i);
    rst_ni = 1'b1;
    cyc();
  endtask

  task automatic test_call();
    rsb_pop_valid_i = 1'b0;
    drive(1'b1, 32'h1000, JAL_X1_P100);
    checks++; if ({rsb_push_en_o, rsb_pop_en_o} !== 2'b10) begin errors++; $display("FAIL call_strobes: got %b want 10", {rsb_push_en_o, rsb_pop_en_o}); end
    checks++; if (rsb_push_addr_o !== 32'h1004) begin errors++; $display("FAIL call_push_addr: got %h want 00001004", rsb_push_addr_o); end
    cyc();
    drive(1'b0, 32'h0, NOP);
    checks++; if ({bus.out_valid_o, bus.out_pred_taken_o, bus.out_is_call_o, bus.out_is_ret_o} !== 4'b1110) begin errors++; $display("FAIL call_flags: got %b want 1110", {bus.out_valid_o, bus.out_pred_taken_o, bus.out_is_call_o, bus.out_is_ret_o}); end
    checks++; if (bus.out_pred_target_o !== 32'h1100) begin errors++; $display("FAIL call_target: got %h want 00001100", bus.out_pred_target_o); end
    checks++; if ({redirect_valid_o, redirect_pc_o} !== {1'b1, 32'h1100}) begin errors++; $display("FAIL call_redirect: got %0h/%h want 1/00001100", redirect_valid_o, redirect_pc_o); end
    checks++; if (call_cnt_o !== 16'd1) begin errors++; $display("FAIL call_cnt: got %0d want 1", call_cnt_o); end
    cyc();
    checks++; if ({bus.out_valid_o, redirect_valid_o} !== 2'b00) begin errors++; $display("FAIL call_drain: got %b want 00", {bus.out_valid_o, redirect_valid_o}); end
  endtask

  task automatic test_return();
    rsb_pop_valid_i = 1'b1; rsb_pop_addr_i = 32'h1004;
    drive(1'b1, 32'h1100, RET_X1);
    checks++; if ({rsb_push_en_o, rsb_pop_en_o} !== 2'b01) begin errors++; $display("FAIL ret_strobes: got %b want 01", {rsb_push_en_o, rsb_pop_en_o}); end
    cyc();
    checks++; if ({bus.out_pred_taken_o, bus.out_is_call_o, bus.out_is_ret_o, bus.out_pred_target_o} !== {3'b101, 32'h1004}) begin errors++; $display("FAIL ret_pred: got %b/%h want 101/00001004", {bus.out_pred_taken_o, bus.out_is_call_o, bus.out_is_ret_o}, bus.out_pred_target_o); end
    checks++; if ({redirect_valid_o, redirect_pc_o} !== {1'b1, 32'h1004}) begin errors++; $display("FAIL ret_redirect: got %0h/%h want 1/00001004", redirect_valid_o, redirect_pc_o); end
    checks++; if ({ret_cnt_o, ret_miss_cnt_o} !== {16'd1, 16'd0}) begin errors++; $display("FAIL ret_cnt: got %0d/%0d want 1/0", ret_cnt_o, ret_miss_cnt_o); end
    // Empty RSB: strobe still fires, no prediction.
    rsb_pop_valid_i = 1'b0;
    drive(1'b1, 32'h2000, RET_X1);
    checks++; if (rsb_pop_en_o !== 1'b1) begin errors++; $display("FAIL miss_pop_en: got %0h want 1", rsb_pop_en_o); end
    cyc();
    checks++; if ({bus.out_pred_taken_o, bus.out_pred_target_o, redirect_valid_o} !== {1'b0, 32'h2004, 1'b0}) begin errors++; $display("FAIL miss_pred: got %0h/%h/%0h want 0/00002004/0", bus.out_pred_taken_o, bus.out_pred_target_o, redirect_valid_o); end
    checks++; if ({ret_cnt_o, ret_miss_cnt_o} !== {16'd2, 16'd1}) begin errors++; $display("FAIL miss_cnt: got %0d/%0d want 2/1", ret_cnt_o, ret_miss_cnt_o); end
  endtask

  task automatic test_coroutine();
    rsb_pop_valid_i = 1'b1; rsb_pop_addr_i = 32'h5550;
    drive(1'b1, 32'h3000, JALR_X1_X5);
    checks++; if ({rsb_push_en_o, rsb_pop_en_o, rsb_push_addr_o} !== {2'b11, 32'h3004}) begin errors++; $display("FAIL co_strobes: got %b/%h want 11/00003004", {rsb_push_en_o, rsb_pop_en_o}, rsb_push_addr_o); end
    cyc();
    checks++; if ({bus.out_is_call_o, bus.out_is_ret_o, bus.out_pred_taken_o, bus.out_pred_target_o} !== {3'b111, 32'h5550}) begin errors++; $display("FAIL co_pred: got %b/%h want 111/00005550", {bus.out_is_call_o, bus.out_is_ret_o, bus.out_pred_taken_o}, bus.out_pred_target_o); end
    checks++; if ({call_cnt_o, ret_cnt_o} !== {16'd2, 16'd3}) begin errors++; $display("FAIL co_cnt: got %0d/%0d want 2/3", call_cnt_o, ret_cnt_o); end
  endtask

  task automatic test_variants();
    drive(1'b1, 32'h3100, JALR_X1_X6);
    checks++; if ({rsb_push_en_o, rsb_pop_en_o} !== 2'b10) begin errors++; $display("FAIL jalr_call_strobes: got %b want 10", {rsb_push_en_o, rsb_pop_en_o}); end
    cyc();
    checks++; if ({bus.out_pred_taken_o, bus.out_pred_target_o, redirect_valid_o} !== {1'b0, 32'h3104, 1'b0}) begin errors++; $display("FAIL jalr_call_pred: got %0h/%h/%0h want 0/00003104/0", bus.out_pred_taken_o, bus.out_pred_target_o, redirect_valid_o); end
    drive(1'b1, 32'h3200, JALR_X1_X1);
    checks++; if ({rsb_push_en_o, rsb_pop_en_o} !== 2'b10) begin errors++; $display("FAIL same_link_strobes: got %b want 10", {rsb_push_en_o, rsb_pop_en_o}); end
    cyc();
    checks++; if ({bus.out_is_call_o, bus.out_is_ret_o, call_cnt_o, ret_cnt_o} !== {2'b10, 16'd4, 16'd3}) begin errors++; $display("FAIL same_link_cls: got %b/%0d/%0d want 10/4/3", {bus.out_is_call_o, bus.out_is_ret_o}, call_cnt_o, ret_cnt_o); end
    drive(1'b1, 32'h0, JAL_X0_M4);
    checks++; if ({rsb_push_en_o, rsb_pop_en_o} !== 2'b00) begin errors++; $display("FAIL jal_x0_strobes: got %b want 00", {rsb_push_en_o, rsb_pop_en_o}); end
    cyc();
    checks++; if ({bus.out_pred_taken_o, bus.out_pred_target_o, redirect_valid_o, redirect_pc_o} !== {1'b1, 32'hFFFFFFFC, 1'b1, 32'hFFFFFFFC}) begin errors++; $display("FAIL jal_wrap: got %0h/%h/%0h/%h want 1/fffffffc/1/fffffffc", bus.out_pred_taken_o, bus.out_pred_target_o, redirect_valid_o, redirect_pc_o); end
    checks++; if (call_cnt_o !== 16'd4) begin errors++; $display("FAIL jal_x0_cnt: got %0d want 4", call_cnt_o); end
    drive(1'b1, 32'h10, NOP);
    checks++; if ({rsb_push_en_o, rsb_pop_en_o} !== 2'b00) begin errors++; $display("FAIL nop_strobes: got %b want 00", {rsb_push_en_o, rsb_pop_en_o}); end
    cyc();
    checks++; if ({bus.out_pred_taken_o, bus.out_is_call_o, bus.out_is_ret_o, bus.out_pred_target_o, bus.out_instr_o} !== {3'b000, 32'h14, NOP}) begin errors++; $display("FAIL nop_slot: got %b/%h/%h want 000/00000014/00000013", {bus.out_pred_taken_o, bus.out_is_call_o, bus.out_is_ret_o}, bus.out_pred_target_o, bus.out_instr_o); end
    drive(1'b1, 32'h20, JALR_F3_X1);
    checks++; if (rsb_pop_en_o !== 1'b0) begin errors++; $display("FAIL funct3_pop_en: got %0h want 0", rsb_pop_en_o); end
    cyc();
    drive(1'b0, 32'h0, NOP);
    cyc();
  endtask

  task automatic test_back_to_back();
    rsb_pop_valid_i = 1'b1; rsb_pop_addr_i = 32'h6004;
    drive(1'b1, 32'h6000, JAL_X1_P100);
    cyc();
    drive(1'b1, 32'h6100, RET_X1);
    checks++; if ({bus.in_ready_o, rsb_pop_en_o, bus.out_valid_o, bus.out_pc_o} !== {3'b111, 32'h6000}) begin errors++; $display("FAIL b2b_first: got %b/%h want 111/00006000", {bus.in_ready_o, rsb_pop_en_o, bus.out_valid_o}, bus.out_pc_o); end
    cyc();
    drive(1'b0, 32'h0, NOP);
    checks++; if ({bus.out_valid_o, bus.out_pc_o, bus.out_pred_target_o, redirect_valid_o, redirect_pc_o} !== {1'b1, 32'h6100, 32'h6004, 1'b1, 32'h6004}) begin errors++; $display("FAIL b2b_second: got %0h/%h/%h/%0h/%h want 1/00006100/00006004/1/00006004", bus.out_valid_o, bus.out_pc_o, bus.out_pred_target_o, redirect_valid_o, redirect_pc_o); end
    checks++; if ({call_cnt_o, ret_cnt_o, ret_miss_cnt_o} !== {16'd5, 16'd4, 16'd1}) begin errors++; $display("FAIL b2b_cnt: got %0d/%0d/%0d want 5/4/1", call_cnt_o, ret_cnt_o, ret_miss_cnt_o); end
    cyc();
  endtask

  task automatic test_backpressure();
    drive(1'b1, 32'h7000, NOP);
    cyc();
    bus.out_ready_i = 1'b0;
    drive(1'b1, 32'h7100, JAL_X1_P100);
    for (int i = 0; i < 3; i++) begin
      checks++; if ({bus.in_ready_o, rsb_push_en_o, rsb_pop_en_o} !== 3'b000) begin errors++; $display("FAIL bp_stall_%0d: got %b want 000", i, {bus.in_ready_o, rsb_push_en_o, rsb_pop_en_o}); end
      checks++; if ({bus.out_valid_o, bus.out_pc_o, bus.out_instr_o} !== {1'b1, 32'h7000, NOP}) begin errors++; $display("FAIL bp_hold_%0d: got %0h/%h/%h want 1/00007000/00000013", i, bus.out_valid_o, bus.out_pc_o, bus.out_instr_o); end
      cyc();
    end
    bus.out_ready_i = 1'b1;
    #1;
    checks++; if ({bus.in_ready_o, rsb_push_en_o} !== 2'b11) begin errors++; $display("FAIL bp_release: got %b want 11", {bus.in_ready_o, rsb_push_en_o}); end
    cyc();
    drive(1'b0, 32'h0, NOP);
    checks++; if ({bus.out_pc_o, call_cnt_o} !== {32'h7100, 16'd6}) begin errors++; $display("FAIL bp_after: got %h/%0d want 00007100/6", bus.out_pc_o, call_cnt_o); end
    cyc();
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h8000, JAL_X0_P100);
    cyc();
    flush_i = 1'b1;
    drive(1'b1, 32'h8100, JAL_X1_P100);
    checks++; if ({redirect_valid_o, bus.in_ready_o, rsb_push_en_o} !== 3'b000) begin errors++; $display("FAIL flush_comb: got %b want 000", {redirect_valid_o, bus.in_ready_o, rsb_push_en_o}); end
    cyc();
    flush_i = 1'b0;
    drive(1'b0, 32'h0, NOP);
    checks++; if ({bus.out_valid_o, redirect_valid_o} !== 2'b00) begin errors++; $display("FAIL flush_slot: got %b want 00", {bus.out_valid_o, redirect_valid_o}); end
    checks++; if ({call_cnt_o, ret_cnt_o, ret_miss_cnt_o} !== {16'd6, 16'd4, 16'd1}) begin errors++; $display("FAIL flush_cnt: got %0d/%0d/%0d want 6/4/1", call_cnt_o, ret_cnt_o, ret_miss_cnt_o); end
  endtask

  task automatic test_saturation();
    drive(1'b1, 32'h9000, JAL_X1_P100);
    for (int i = 0; i < 65529; i++) @(posedge clk_i);
    #1;
    checks++; if (call_cnt_o !== 16'hFFFF) begin errors++; $display("FAIL sat_reach: got %h want ffff", call_cnt_o); end
    cyc(); cyc(); cyc();
    checks++; if ({call_cnt_o, ret_cnt_o} !== {16'hFFFF, 16'd4}) begin errors++; $display("FAIL sat_hold: got %h/%0d want ffff/4", call_cnt_o, ret_cnt_o); end
  endtask

  task automatic test_reset_mid();
    #2;
    rst_ni = 1'b0;
    #1;
    checks++; if ({bus.out_valid_o, redirect_valid_o, rsb_push_en_o, call_cnt_o, ret_cnt_o} !== 35'h0) begin errors++; $display("FAIL mid_reset: got %0h/%0h/%0h/%h/%h want all 0", bus.out_valid_o, redirect_valid_o, rsb_push_en_o, call_cnt_o, ret_cnt_o); end
    drive(1'b0, 32'h0, NOP);
    @(negedge clk_i);
    rst_ni = 1'b1;
    cyc();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_call();
    test_return();
    test_coroutine();
    test_variants();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_saturation();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
